alu_ctrl_shift_seq: RTL
=======================

// Module: alu_ctrl_shift_seq
// PURPOSE
//  Parametrised, registered successor of the ALU control decoder. Decodes
//  ALUOp/funct into the 4-bit ALU control code and carries it into EX through
//  a valid/ready stage with flush. Also executes right-arithmetic shifts
//  (sra/srav) itself as an iterative multi-cycle shifter.
//  Sits between the decoder (ID) and the ALU/EX stage.
// PARAMETERS
//  DATA_W     32  operand/result width; power of 2, >= 8
//  ALUOP_W    3   width of ALUOp_i
//  SHIFT_STEP 1   bits shifted per cycle in SHIFT state; power of 2, <= DATA_W/2
//  SHAMT_W    $clog2(DATA_W)  derived, not overridden
// PORTS
//  clk_i          in   1        clock, rising edge
//  rst_i          in   1        async reset, active-high
//  valid_i        in   1        op presented by ID
//  ready_o        out  1        unit can accept op this cycle
//  funct_i        in   6        R-type funct field
//  ALUOp_i        in   ALUOP_W  op class from decoder
//  shamt_i        in   SHAMT_W  constant shift amount (sra)
//  rs_data_i      in   DATA_W   rs value; [SHAMT_W-1:0] = srav amount
//  rt_data_i      in   DATA_W   rt value, shifted operand
//  flush_i        in   1        sync flush of in-flight op
//  valid_o        out  1        outputs valid to EX
//  ready_i        in   1        EX accepts output
//  ALUCtrl_o      out  4        ALU control code
//  shift_result_o out  DATA_W   shift result; valid when is_shift_o
//  is_shift_o     out  1        op was sra/srav; EX bypasses ALU
//  illegal_o      out  1        op undecodable; ALUCtrl_o=4'hF
// BEHAVIOUR
//  Codes: AND=0 OR=1 NAND=2 NOR=3 ADDU=4 SUBU=5 SLT=6 EQUAL=7 SRA=8 SLTU=9 LUI=10 NOP=15.
//  ALUOp: R_TYPE=0 ADDI=1 SLTIU=2 BEQ=3 LUI=4 ORI=5 BNE=6.
//  R_TYPE funct: 100001->ADDU, 100011->SUBU, 100100->AND, 100101->OR,
//   101010->SLT, 000011->SRA (amount shamt_i), 000111->SRA (amount rs_data_i[SHAMT_W-1:0]).
//  ADDI->ADDU, SLTIU->SLTU, BEQ->SUBU, BNE->SUBU, LUI->LUI, ORI->OR.
//  Any other ALUOp/funct -> NOP, illegal_o=1, is_shift_o=0.
//  Reset: state IDLE, valid_o=0, ALUCtrl_o=0, shift_result_o=0, is_shift_o=0, illegal_o=0.
//  Accept = valid_i & ready_o. ready_o = !flush_i & (IDLE | (HOLD & ready_i)).
//  FSM states: IDLE, SHIFT, HOLD.
//   IDLE/HOLD accept, non-shift or amount 0 -> HOLD next cycle. Outputs are
//    registered, so latency is 1 cycle; shift_result_o = rt_data_i for amount 0.
//   Accept, shift amount n>0 -> SHIFT. Loads rt_data_i and n.
//    Each SHIFT cycle: acc >>>= min(SHIFT_STEP, rem); rem -= that. The shift
//    sign-extends from acc[DATA_W-1].
//    When rem reaches 0 -> HOLD. valid_o rises ceil(n/SHIFT_STEP)+1 cycles
//    after accept.
//   HOLD: valid_o=1 and all outputs held stable while !ready_i. On ready_i with
//    no new accept -> IDLE. With a new accept, go to HOLD or SHIFT as above,
//    back-to-back with no bubble.
//   SHIFT: valid_o=0, ready_o=0.
//  flush_i (priority over all): next state IDLE, valid_o=0. The in-flight op is
//   discarded and nothing is accepted that cycle. Data outputs keep their last values.
//  rst_i mid-SHIFT: immediate return to reset values; no partial result escapes.
//  Shift counter is SHAMT_W+1 bits; it never wraps for n = DATA_W-1.
// TESTING
//  1 ALUOp=0 funct=100011, ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=5,
//    is_shift_o=0, and one valid pulse only.
//  2 sra shamt=4, rt=32'h8000_0000, STEP=1 -> ready_o low for 4 cycles, then
//    valid_o=1, ALUCtrl_o=8, shift_result_o=32'hF800_0000 (5 cycles after accept).
//  3 srav rs=32'h0000_0023 (amount 3), rt=32'h0000_00F0, STEP=2 -> result
//    32'h0000_001E after 2 SHIFT cycles + 1.
//  4 ready_i=0 for 3 cycles in HOLD -> outputs stable, ready_o=0. ready_i=1
//    with a queued ADDI -> accepted same cycle, next valid ALUCtrl_o=4.
//  5 flush_i in 2nd SHIFT cycle of shamt=8 -> IDLE next cycle, no valid_o.
//    A later op completes normally.
//  6 ALUOp=7, and ALUOp=0 funct=111111 -> ALUCtrl_o=15, illegal_o=1. rst_i
//    pulse mid-SHIFT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_ctrl_shift_seq_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_shift_seq_if
// Handshake and data bundle between the ID-side decoder, the ALU control /
// arithmetic-shift unit and the EX stage.
//   slave  : the alu_ctrl_shift_seq unit
//   master : the ID/EX environment driving and consuming the unit
// Signals:
//   valid_i/ready_o          ID -> unit handshake
//   funct_i, ALUOp_i         decode inputs
//   shamt_i                  constant shift amount (sra)
//   rs_data_i, rt_data_i     operands (rs low bits = srav amount, rt = shifted)
//   flush_i                  synchronous flush of the in-flight op
//   valid_o/ready_i          unit -> EX handshake
//   ALUCtrl_o, shift_result_o, is_shift_o, illegal_o   results to EX
// -----------------------------------------------------------------------------
interface alu_ctrl_shift_seq_if #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 3
);
    localparam int SHAMT_W = $clog2(DATA_W);

    logic                valid_i;
    logic                ready_o;
    logic [5:0]          funct_i;
    logic [ALUOP_W-1:0]  ALUOp_i;
    logic [SHAMT_W-1:0]  shamt_i;
    logic [DATA_W-1:0]   rs_data_i;
    logic [DATA_W-1:0]   rt_data_i;
    logic                flush_i;
    logic                valid_o;
    logic                ready_i;
    logic [3:0]          ALUCtrl_o;
    logic [DATA_W-1:0]   shift_result_o;
    logic                is_shift_o;
    logic                illegal_o;

    modport slave (
        input  valid_i, funct_i, ALUOp_i, shamt_i, rs_data_i, rt_data_i,
               flush_i, ready_i,
        output ready_o, valid_o, ALUCtrl_o, shift_result_o, is_shift_o,
               illegal_o
    );

    modport master (
        output valid_i, funct_i, ALUOp_i, shamt_i, rs_data_i, rt_data_i,
               flush_i, ready_i,
        input  ready_o, valid_o, ALUCtrl_o, shift_result_o, is_shift_o,
               illegal_o
    );
endinterface

// File: rtl/alu_ctrl_shift_seq.sv
// -----------------------------------------------------------------------------
// alu_ctrl_shift_seq
// Registered ALU control decoder with a valid/ready output stage and flush.
// Right-arithmetic shifts (sra/srav) are executed here by an iterative
// shifter moving SHIFT_STEP bits per cycle; EX bypasses the ALU for them.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active high
//   bus    : alu_ctrl_shift_seq_if.slave (handshakes, decode inputs, results)
// -----------------------------------------------------------------------------
module alu_ctrl_shift_seq #(
    parameter int DATA_W     = 32,
    parameter int ALUOP_W    = 3,
    parameter int SHIFT_STEP = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    alu_ctrl_shift_seq_if.slave  bus
);
    localparam int SHAMT_W = $clog2(DATA_W);
    // One extra bit so an amount of DATA_W-1 never wraps while counting down.
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] C_AND  = 4'd0;
    localparam logic [3:0] C_OR   = 4'd1;
    localparam logic [3:0] C_ADDU = 4'd4;
    localparam logic [3:0] C_SUBU = 4'd5;
    localparam logic [3:0] C_SLT  = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd8;
    localparam logic [3:0] C_SLTU = 4'd9;
    localparam logic [3:0] C_LUI  = 4'd10;
    localparam logic [3:0] C_NOP  = 4'd15;

    localparam logic [ALUOP_W-1:0] OP_RTYPE = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_ADDI  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_SLTIU = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_BEQ   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_LUI   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_ORI   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_BNE   = ALUOP_W'(6);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_ctrl;
    logic                r_illegal;
    logic                r_is_shift;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_rem;

    logic [3:0]          w_code;
    logic                w_illegal;
    logic                w_is_shift;
    logic [SHAMT_W-1:0]  w_amount;
    logic                w_ready;
    logic                w_accept;
    logic                w_start_shift;
    logic [CNT_W-1:0]    w_step;
    logic [CNT_W-1:0]    w_rem_next;
    logic [DATA_W-1:0]   w_acc_next;
    logic                w_shift_done;

    // Decode ALUOp/funct into the control code, shift flag and shift amount.
    always_comb begin
        w_code     = C_NOP;
        w_illegal  = 1'b1;
        w_is_shift = 1'b0;
        w_amount   = {SHAMT_W{1'b0}};
        case (bus.ALUOp_i)
            OP_RTYPE: begin
                case (bus.funct_i)
                    6'b100001: begin w_code = C_ADDU; w_illegal = 1'b0; end
                    6'b100011: begin w_code = C_SUBU; w_illegal = 1'b0; end
                    6'b100100: begin w_code = C_AND;  w_illegal = 1'b0; end
                    6'b100101: begin w_code = C_OR;   w_illegal = 1'b0; end
                    6'b101010: begin w_code = C_SLT;  w_illegal = 1'b0; end
                    6'b000011: begin
                        w_code     = C_SRA;
                        w_illegal  = 1'b0;
                        w_is_shift = 1'b1;
                        w_amount   = bus.shamt_i;
                    end
                    6'b000111: begin
                        w_code     = C_SRA;
                        w_illegal  = 1'b0;
                        w_is_shift = 1'b1;
                        w_amount   = bus.rs_data_i[SHAMT_W-1:0];
                    end
                    default:   begin w_code = C_NOP;  w_illegal = 1'b1; end
                endcase
            end
            OP_ADDI:  begin w_code = C_ADDU; w_illegal = 1'b0; end
            OP_SLTIU: begin w_code = C_SLTU; w_illegal = 1'b0; end
            OP_BEQ:   begin w_code = C_SUBU; w_illegal = 1'b0; end
            OP_BNE:   begin w_code = C_SUBU; w_illegal = 1'b0; end
            OP_LUI:   begin w_code = C_LUI;  w_illegal = 1'b0; end
            OP_ORI:   begin w_code = C_OR;   w_illegal = 1'b0; end
            default:  begin w_code = C_NOP;  w_illegal = 1'b1; end
        endcase
    end

    // Handshake and one shifter step; the last step may be shorter than SHIFT_STEP.
    always_comb begin
        w_ready       = !bus.flush_i &&
                        ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.ready_i));
        w_accept      = bus.valid_i && w_ready;
        w_start_shift = w_is_shift && (w_amount != {SHAMT_W{1'b0}});
        if (r_rem > CNT_W'(SHIFT_STEP)) begin
            w_step = CNT_W'(SHIFT_STEP);
        end else begin
            w_step = r_rem;
        end
        w_rem_next    = r_rem - w_step;
        w_acc_next    = DATA_W'($signed(r_acc) >>> w_step);
        w_shift_done  = (w_rem_next == {CNT_W{1'b0}});
    end

    // Next-state logic; flush overrides everything and drops the in-flight op.
    always_comb begin
        w_state_next = r_state;
        if (bus.flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        w_state_next = w_start_shift ? S_SHIFT : S_HOLD;
                    end else if ((r_state == S_HOLD) && bus.ready_i) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                S_SHIFT: begin
                    if (w_shift_done) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_state_next = S_SHIFT;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result registers: updated only when an op completes, so a flushed or
    // reset shift never exposes a partial value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl     <= 4'd0;
            r_illegal  <= 1'b0;
            r_is_shift <= 1'b0;
            r_result   <= {DATA_W{1'b0}};
            r_acc      <= {DATA_W{1'b0}};
            r_rem      <= {CNT_W{1'b0}};
        end else if (!bus.flush_i) begin
            if (w_accept) begin
                if (w_start_shift) begin
                    r_acc <= bus.rt_data_i;
                    r_rem <= {1'b0, w_amount};
                end else begin
                    r_ctrl     <= w_code;
                    r_illegal  <= w_illegal;
                    r_is_shift <= w_is_shift;
                    if (w_is_shift) begin
                        r_result <= bus.rt_data_i;
                    end
                end
            end else if (r_state == S_SHIFT) begin
                r_acc <= w_acc_next;
                r_rem <= w_rem_next;
                if (w_shift_done) begin
                    r_ctrl     <= C_SRA;
                    r_illegal  <= 1'b0;
                    r_is_shift <= 1'b1;
                    r_result   <= w_acc_next;
                end
            end
        end
    end

    assign bus.ready_o        = w_ready;
    assign bus.valid_o        = (r_state == S_HOLD);
    assign bus.ALUCtrl_o      = r_ctrl;
    assign bus.illegal_o      = r_illegal;
    assign bus.is_shift_o     = r_is_shift;
    assign bus.shift_result_o = r_result;
endmodule
